// File: rtl/psum_collector_pkg.sv
// Shared constants, FSM encoding and requantize helper for the partial-sum collector.
// Pure declarations, no latency.
// No flow control.
package psum_pkg;

    localparam int PSUM_W_DEF = 14;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // Clamp an already-shifted value to the largest out_w-bit unsigned number.
    function automatic logic [31:0] requant_sat(input logic [31:0] q, input int out_w);
        logic [31:0] max_val;
        max_val = (32'd1 << out_w) - 32'd1;
        return (q > max_val) ? max_val : q;
    endfunction

endpackage

// File: rtl/psum_out_fifo.sv
// Synchronous FIFO between requantizer and ofmap writer; exposes fill count for stall.
// Data visible one cycle after push; pop_data is zero while empty.
// Push while full is discarded unless a pop happens in the same cycle.
module psum_out_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/psum_collector.sv
// Accumulates PE-column psums over channel passes and requantizes the last pass to OUT_W bits; PSUM_COLLECTOR_SAT_EN selects clamping over truncation.
// Psum accepted in cycle N appears on out_data in N+1 when the FIFO was empty.
// stall asks the array to stop with two FIFO slots left; a psum arriving on a full FIFO is dropped and sets err.
module psum_collector
    import psum_pkg::*;
#(
    parameter int PSUM_W     = PSUM_W_DEF,
    parameter int ACC_W      = 20,
    parameter int OUT_W      = 8,
    parameter int MAX_LEN    = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic [5:0]                   cfg_passes_m1,
    input  logic [4:0]                   cfg_shift,
    input  logic                         en,
    input  logic                         psum_valid,
    input  logic [PSUM_W-1:0]            psum_in,
    output logic                         stall,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_W-1:0]             out_data,
    output logic                         out_last
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [1:0]       state;
    logic [LEN_W-1:0] len_q;
    logic [5:0]       passes_q;
    logic [4:0]       shift_q;
    logic [IDX_W-1:0] idx;
    logic [5:0]       pass;

    logic [ACC_W-1:0] acc_buf [MAX_LEN];

    logic             acc_en;
    logic             last_idx;
    logic             last_pass;
    logic [ACC_W-1:0] acc_prev;
    logic [ACC_W-1:0] acc_sum;
    logic [ACC_W-1:0] acc_shr;
    logic [OUT_W-1:0] q_out;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             drop;
    logic [CNT_W-1:0] fifo_count;
    logic [OUT_W:0]   fifo_rd;

    assign acc_en    = en & psum_valid & (state == ST_RUN);
    assign last_idx  = (LEN_W'(idx) == len_q - LEN_W'(1));
    assign last_pass = (pass == passes_q);

    // Pass 0 overwrites the buffer, so stale contents never leak into a new job.
    assign acc_prev = (pass == 6'd0) ? '0 : acc_buf[idx];
    assign acc_sum  = acc_prev + ACC_W'(psum_in);
    assign acc_shr  = acc_sum >> shift_q;

`ifdef PSUM_COLLECTOR_SAT_EN
    assign q_out = OUT_W'(requant_sat(32'(acc_shr), OUT_W));
`else
    assign q_out = acc_shr[OUT_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (acc_en) acc_buf[idx] <= acc_sum;
    end

    assign fifo_push = acc_en & last_pass;
    assign fifo_pop  = out_valid & out_ready;
    assign drop      = fifo_push & fifo_full & ~fifo_pop;

    psum_out_fifo #(
        .WIDTH (OUT_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({last_idx, q_out}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign out_data  = fifo_rd[OUT_W-1:0];
    assign out_last  = fifo_rd[OUT_W];
    assign stall     = (int'(fifo_count) >= FIFO_DEPTH - 2);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_FLUSH) & fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            passes_q <= '0;
            shift_q  <= '0;
            idx      <= '0;
            pass     <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_RUN;
                        len_q    <= cfg_len;
                        passes_q <= cfg_passes_m1;
                        shift_q  <= cfg_shift;
                        idx      <= '0;
                        pass     <= '0;
                        err      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (acc_en) begin
                        if (last_idx) begin
                            idx <= '0;
                            if (last_pass) state <= ST_FLUSH;
                            else           pass  <= pass + 6'd1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                    if (drop) err <= 1'b1;
                end
                ST_FLUSH: begin
                    if (fifo_empty) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: queue-level reference model checked every cycle, plus literal result checks per scenario.
`timescale 1ns/1ps
module tb_psum_collector;
    localparam int MAX_LEN    = 32;
    localparam int FIFO_DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  cfg_len;
    logic [5:0]  cfg_passes_m1;
    logic [4:0]  cfg_shift;
    logic        en;
    logic        psum_valid;
    logic [13:0] psum_in;
    logic        stall;
    logic        busy;
    logic        done;
    logic        err;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;

    psum_collector dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cfg_len       (cfg_len),
        .cfg_passes_m1 (cfg_passes_m1),
        .cfg_shift     (cfg_shift),
        .en            (en),
        .psum_valid    (psum_valid),
        .psum_in       (psum_in),
        .stall         (stall),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a job is a list of rows summed over passes; results sit in a bounded queue.
    bit         m_ok = 0;
    bit         m_active = 0;
    bit         m_flush = 0;
    bit         m_err = 0;
    int         m_len, m_passes, m_shift, m_pos, m_pass;
    int         m_acc [MAX_LEN];
    logic [8:0] mq  [$];
    logic [8:0] got [$];

    task automatic model_step();
        bit         pop;
        int         sum, qv, d;
        logic [8:0] e;
        pop = (mq.size() > 0) && out_ready;
        if (pop) void'(mq.pop_front());
        if (m_flush && mq.size() == 0 && !pop) begin
            m_active = 0;
            m_flush  = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1;
                m_len    = int'(cfg_len);
                m_passes = int'(cfg_passes_m1);
                m_shift  = int'(cfg_shift);
                m_pos    = 0;
                m_pass   = 0;
                m_err    = 0;
            end
        end else if (!m_flush && en && psum_valid) begin
            sum = ((m_pass == 0) ? 0 : m_acc[m_pos]) + int'(psum_in);
            sum = sum & 32'h000F_FFFF;
            m_acc[m_pos] = sum;
            if (m_pass == m_passes) begin
                qv = sum >> m_shift;
`ifdef PSUM_COLLECTOR_SAT_EN
                d = (qv > 255) ? 255 : qv;
`else
                d = qv % 256;
`endif
                e = {(m_pos == m_len - 1), d[7:0]};
                if (mq.size() < FIFO_DEPTH) mq.push_back(e);
                else                        m_err = 1;
            end
            m_pos++;
            if (m_pos == m_len) begin
                m_pos = 0;
                if (m_pass == m_passes) m_flush = 1;
                else                    m_pass++;
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (m_ok) begin
            chk("busy",      32'(busy),      32'(m_active));
            chk("stall",     32'(stall),     32'(mq.size() >= FIFO_DEPTH - 2));
            chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
            chk("err",       32'(err),       32'(m_err));
            chk("done",      32'(done),      32'(m_flush && mq.size() == 0));
            if (mq.size() > 0) begin
                chk("out_data", 32'(out_data), 32'(mq[0][7:0]));
                chk("out_last", 32'(out_last), 32'(mq[0][8]));
            end
        end
        if (out_valid && out_ready) got.push_back({out_last, out_data});
        if (!rst_n) begin
            m_ok     = 1;
            m_active = 0;
            m_flush  = 0;
            m_err    = 0;
            mq.delete();
        end else begin
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int len, input int passes, input int shift);
        cfg_len       = 6'(len);
        cfg_passes_m1 = 6'(passes);
        cfg_shift     = 5'(shift);
        start         = 1'b1;
        tick();
        start         = 1'b0;
    endtask

    task automatic feed(input int v);
        en         = 1'b1;
        psum_valid = 1'b1;
        psum_in    = 14'(v);
        tick();
        en         = 1'b0;
        psum_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk(name, 32'(seen), 32'd1);
        tick();
    endtask

    task automatic chk_got(input string name, input int idx, input int data, input int last);
        if (idx < got.size()) begin
            chk({name, "_data"}, 32'(got[idx][7:0]), 32'(data));
            chk({name, "_last"}, 32'(got[idx][8]),   32'(last));
        end else begin
            chk({name, "_missing"}, 32'(got.size()), 32'(idx + 1));
        end
    endtask

    int e1 [4] = '{10, 20, 30, 40};
    int e5 [4] = '{2, 3, 3, 4};

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_len = '0; cfg_passes_m1 = '0; cfg_shift = '0;
        en = 1'b0; psum_valid = 1'b0; psum_in = '0; out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_busy",      32'(busy),      0);
        chk("rst_stall",     32'(stall),     0);
        chk("rst_done",      32'(done),      0);
        chk("rst_err",       32'(err),       0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_last",  32'(out_last),  0);
        chk("rst_out_data",  32'(out_data),  0);
        rst_n = 1'b1;
        tick();

        // Single pass, row of 4
        got.delete();
        out_ready = 1'b1;
        start_job(4, 0, 0);
        foreach (e1[i]) feed(e1[i]);
        wait_done("t1_done");
        chk("t1_count", 32'(got.size()), 4);
        for (int i = 0; i < 4; i++) chk_got("t1", i, e1[i], (i == 3) ? 1 : 0);

        // Three passes, shift 2: (3*100)>>2 = 75, (3*200)>>2 = 150
        got.delete();
        start_job(2, 2, 2);
        for (int p = 0; p < 3; p++) begin
            feed(100);
            feed(200);
            if (p == 1) chk("t2_no_early_out", 32'(got.size()), 0);
        end
        wait_done("t2_done");
        chk("t2_count", 32'(got.size()), 2);
        chk_got("t2_0", 0, 75, 0);
        chk_got("t2_1", 1, 150, 1);

        // Saturation vs truncation of 300
        got.delete();
        start_job(1, 0, 0);
        feed(300);
        wait_done("t3_done");
`ifdef PSUM_COLLECTOR_SAT_EN
        chk_got("t3", 0, 255, 1);
`else
        chk_got("t3", 0, 44, 1);
`endif

        // Backpressure: sink stalled, array ignores stall
        got.delete();
        out_ready = 1'b0;
        start_job(8, 0, 0);
        feed(1);
        chk("t4_stall_cnt1", 32'(stall), 0);
        feed(2);
        chk("t4_stall_cnt2", 32'(stall), 1);
        feed(3);
        feed(4);
        chk("t4_err_before", 32'(err), 0);
        feed(5);
        chk("t4_err_after", 32'(err), 1);
        for (int v = 6; v <= 8; v++) feed(v);
        chk("t4_head", 32'(out_data), 1);
        chk("t4_busy", 32'(busy), 1);
        out_ready = 1'b1;
        wait_done("t4_done");
        chk("t4_count", 32'(got.size()), 4);
        for (int i = 0; i < 4; i++) chk_got("t4", i, i + 1, 0);
        chk("t4_err_sticky", 32'(err), 1);

        // Reset mid-run, then a fresh job (shift 1)
        got.delete();
        start_job(4, 0, 0);
        chk("t5_err_cleared", 32'(err), 0);
        feed(1);
        feed(2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_busy",      32'(busy),      0);
        chk("t5_out_valid", 32'(out_valid), 0);
        chk("t5_done",      32'(done),      0);
        chk("t5_stall",     32'(stall),     0);
        chk("t5_out_data",  32'(out_data),  0);
        got.delete();
        start_job(4, 0, 1);
        for (int v = 5; v <= 8; v++) feed(v);
        wait_done("t5_done_new");
        chk("t5_count", 32'(got.size()), 4);
        for (int i = 0; i < 4; i++) chk_got("t5", i, e5[i], (i == 3) ? 1 : 0);

        // start during RUN with different cfg is ignored
        got.delete();
        start_job(3, 0, 0);
        feed(7);
        cfg_len   = 6'd1;
        cfg_shift = 5'd3;
        start     = 1'b1;
        feed(8);
        start     = 1'b0;
        feed(9);
        wait_done("t6_done");
        chk("t6_count", 32'(got.size()), 3);
        chk_got("t6_0", 0, 7, 0);
        chk_got("t6_1", 1, 8, 0);
        chk_got("t6_2", 2, 9, 1);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
